// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams an NUM_OF_WORDS-word message out of word memory
// as padded 16-word blocks (0x80 marker, zero fill, 64-bit bit length) over valid/ready.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       message_addr,
  output logic [15:0]       mem_addr,
  output logic              mem_we,
  input  logic [31:0]       mem_read_data,
  output logic [15:0][31:0] block,
  output logic              block_valid,
  input  logic              block_ready,
  output logic [7:0]        block_index,
  output logic              last_block,
  output logic              done
);

  localparam int          NB        = (NUM_OF_WORDS + 18) / 16;
  localparam logic [15:0] MSG_WORDS = 16'(NUM_OF_WORDS);
  localparam logic [15:0] LEN_LO_G  = 16'(NB * 16 - 1);
  localparam logic [31:0] LEN_LO    = 32'(NUM_OF_WORDS * 32);
  localparam logic [7:0]  LAST_IDX  = 8'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, PAD, PRESENT, DONE
  } state_t;

  state_t      state, next_state;
  logic [15:0] base_addr;
  logic [15:0] g;
  logic [3:0]  slot;
  logic [31:0] pad_word;
  logic        is_last;

  assign is_last     = (block_index == LAST_IDX);
  assign block_valid = (state == PRESENT);
  assign last_block  = block_valid && is_last;
  assign done        = (state == DONE);
  assign mem_we      = 1'b0;

  // The high length word is always zero for legal lengths, so it falls into the zero fill.
  always_comb begin
    pad_word = 32'h0;
    if (g == MSG_WORDS)
      pad_word = 32'h8000_0000;
    else if (g == LEN_LO_G)
      pad_word = LEN_LO;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (MSG_WORDS != 16'd0) ? ISSUE : PAD;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = CAPTURE;
      CAPTURE,
      PAD: begin
        if (slot == 4'd15)
          next_state = PRESENT;
        else if ((g + 16'd1) < MSG_WORDS)
          next_state = ISSUE;
        else
          next_state = PAD;
      end
      // g already points at the first word of the next block here.
      PRESENT: begin
        if (block_ready)
          next_state = is_last ? DONE : ((g < MSG_WORDS) ? ISSUE : PAD);
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_addr   <= 16'h0;
      g           <= 16'h0;
      slot        <= 4'h0;
      mem_addr    <= 16'h0;
      block       <= '0;
      block_index <= 8'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_addr   <= message_addr;
            g           <= 16'h0;
            slot        <= 4'h0;
            block_index <= 8'h0;
          end
        end
        ISSUE: mem_addr <= base_addr + g;
        CAPTURE: begin
          block[slot] <= mem_read_data;
          slot        <= slot + 4'd1;
          g           <= g + 16'd1;
        end
        PAD: begin
          block[slot] <= pad_word;
          slot        <= slot + 4'd1;
          g           <= g + 16'd1;
        end
        PRESENT: begin
          if (block_ready && !is_last)
            block_index <= block_index + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: three instances (N=20, 13, 14) driven with
// random messages; a negedge monitor checks every presented block against a padding model.
module tb_sha256_msg_padder;

  localparam int NW [3] = '{20, 13, 14};

  typedef struct {
    logic [15:0][31:0] w;
    logic [7:0]        idx;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n    [3];
  logic              start    [3];
  logic [15:0]       addr_in  [3];
  logic [15:0]       mem_addr [3];
  logic              mem_we   [3];
  logic [31:0]       rd       [3];
  logic [15:0][31:0] blk      [3];
  logic              bv       [3];
  logic              br       [3];
  logic [7:0]        bidx     [3];
  logic              lb       [3];
  logic              dn       [3];

  logic [15:0] mbase     [3];
  bit          mmode     [3];
  logic [31:0] seed      [3];
  bit          pend_done [3];
  exp_t        exp_q     [3][$];
  exp_t        mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sha256_msg_padder #(.NUM_OF_WORDS(20)) dut20 (
    .clk(clk), .reset_n(rst_n[0]), .start(start[0]), .message_addr(addr_in[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_read_data(rd[0]), .block(blk[0]),
    .block_valid(bv[0]), .block_ready(br[0]), .block_index(bidx[0]),
    .last_block(lb[0]), .done(dn[0])
  );

  sha256_msg_padder #(.NUM_OF_WORDS(13)) dut13 (
    .clk(clk), .reset_n(rst_n[1]), .start(start[1]), .message_addr(addr_in[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_read_data(rd[1]), .block(blk[1]),
    .block_valid(bv[1]), .block_ready(br[1]), .block_index(bidx[1]),
    .last_block(lb[1]), .done(dn[1])
  );

  sha256_msg_padder #(.NUM_OF_WORDS(14)) dut14 (
    .clk(clk), .reset_n(rst_n[2]), .start(start[2]), .message_addr(addr_in[2]),
    .mem_addr(mem_addr[2]), .mem_we(mem_we[2]), .mem_read_data(rd[2]), .block(blk[2]),
    .block_valid(bv[2]), .block_ready(br[2]), .block_index(bidx[2]),
    .last_block(lb[2]), .done(dn[2])
  );

  // Memory contents: mode 0 holds i+1 at base+i, mode 1 a seeded address hash.
  function automatic logic [31:0] memval(input int i, input logic [15:0] a);
    logic [15:0] d;
    d = a - mbase[i];
    if (!mmode[i])
      return {16'h0, d} + 32'd1;
    return {a, ~a} ^ seed[i];
  endfunction

  // While block b is shown, the last read issued was the last message word up to that block.
  function automatic logic [15:0] exp_maddr(input int i, input logic [7:0] idx);
    int last_g;
    last_g = int'(idx) * 16 + 15;
    if (last_g > NW[i] - 1)
      last_g = NW[i] - 1;
    return mbase[i] + 16'(last_g);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      rd[i] <= memval(i, mem_addr[i]);

  task automatic checkOutput(input string nm, input int i, input logic [511:0] act,
                             input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s dut%0d: got %0h required %0h", nm, i, act, req);
    end
  endtask

  task automatic check_reset(input int i);
    checkOutput("rst_mem_addr", i, 512'(mem_addr[i]), 512'(0));
    checkOutput("rst_mem_we", i, 512'(mem_we[i]), 512'(0));
    checkOutput("rst_block", i, blk[i], 512'(0));
    checkOutput("rst_block_valid", i, 512'(bv[i]), 512'(0));
    checkOutput("rst_block_index", i, 512'(bidx[i]), 512'(0));
    checkOutput("rst_last_block", i, 512'(lb[i]), 512'(0));
    checkOutput("rst_done", i, 512'(dn[i]), 512'(0));
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        pend_done[i] = 1'b0;
      end else begin
        checkOutput("done_pulse", i, 512'(dn[i]), 512'(pend_done[i]));
        pend_done[i] = 1'b0;
        if (bv[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_block dut%0d: got block_index %0d required no block",
                     i, bidx[i]);
          end else begin
            checkOutput("block_words", i, blk[i], exp_q[i][0].w);
            checkOutput("mem_addr_hold", i, 512'(mem_addr[i]), 512'(exp_maddr(i, exp_q[i][0].idx)));
            if (br[i]) begin
              mon_e = exp_q[i].pop_front();
              checkOutput("block_index", i, 512'(bidx[i]), 512'(mon_e.idx));
              checkOutput("last_block", i, 512'(lb[i]), 512'(mon_e.last));
              checkOutput("mem_we", i, 512'(mem_we[i]), 512'(0));
              pend_done[i] = mon_e.last;
            end
          end
        end
      end
    end
  end

  // bp 0: always ready, with latency checks; bp 1: 20-cycle stall on block 0 then random ready.
  task automatic applyStimulus(input int i, input logic [15:0] b, input bit hashed,
                               input int bp, input bit noisy);
    int   n, nb, g, cost, vc, cyc, hold, done_cyc, exp_rise;
    bit   got_done, prev_bv;
    exp_t e;
    int   rise_q[$];

    n          = NW[i];
    nb         = (n + 18) / 16;
    mbase[i]   = b;
    mmode[i]   = hashed;
    seed[i]    = $urandom;
    vc         = 0;
    for (int blkn = 0; blkn < nb; blkn++) begin
      cost = 0;
      for (int s = 0; s < 16; s++) begin
        g = blkn * 16 + s;
        if (g < n)                e.w[s] = memval(i, b + 16'(g));
        else if (g == n)          e.w[s] = 32'h8000_0000;
        else if (g == nb * 16 - 1) e.w[s] = 32'(n * 32);
        else                      e.w[s] = 32'h0;
        cost += (g < n) ? 3 : 1;
      end
      e.idx  = 8'(blkn);
      e.last = (blkn == nb - 1);
      exp_q[i].push_back(e);
      vc = (blkn == 0) ? 1 + cost : vc + 1 + cost;
      rise_q.push_back(vc);
    end
    done_cyc = vc + 1;

    start[i]   = 1'b1;
    addr_in[i] = b;
    @(posedge clk);
    #1;
    start[i]   = 1'b0;
    addr_in[i] = 16'($urandom);
    cyc      = 1;
    hold     = 0;
    got_done = 1'b0;
    prev_bv  = 1'b0;
    while (cyc < 3000) begin
      if (bv[i] && !prev_bv && bp == 0 && rise_q.size() != 0) begin
        exp_rise = rise_q.pop_front();
        checkOutput("valid_cycle", i, 512'(cyc), 512'(exp_rise));
      end
      if (dn[i]) begin
        if (bp == 0)
          checkOutput("done_cycle", i, 512'(cyc), 512'(done_cyc));
        got_done = 1'b1;
        break;
      end
      prev_bv = bv[i];
      if (bp == 0)
        br[i] = 1'b1;
      else if (bv[i] && hold < 20) begin
        br[i] = 1'b0;
        hold++;
      end else
        br[i] = 1'($urandom_range(0, 1));
      if (noisy) begin
        start[i]   = ($urandom_range(0, 5) == 0);
        addr_in[i] = 16'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start[i] = 1'b0;
    br[i]    = 1'b1;
    checkOutput("done_seen", i, 512'(got_done), 512'(1));
    checkOutput("blocks_left", i, 512'(exp_q[i].size()), 512'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]   = 1'b0;
      start[i]   = 1'b0;
      addr_in[i] = 16'h0;
      br[i]      = 1'b1;
      mbase[i]   = 16'h0;
      mmode[i]   = 1'b0;
      seed[i]    = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_reset(i);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] sequential message, N=20");
    applyStimulus(0, 16'h0100, 1'b0, 0, 1'b0);
    applyStimulus(1, 16'($urandom), 1'b1, 0, 1'b0);
    applyStimulus(2, 16'($urandom), 1'b1, 0, 1'b0);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++)
      applyStimulus(i, 16'($urandom), 1'b1, 1, 1'b0);

    $display("[TB] reset at cycle 30 of fill");
    mbase[0]   = 16'h0100;
    mmode[0]   = 1'b0;
    addr_in[0] = 16'h0100;
    start[0]   = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    #1;
    check_reset(0);
    repeat (2) @(posedge clk);
    #1;
    check_reset(0);
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 16'h0100, 1'b0, 0, 1'b0);

    $display("[TB] address wrap with stray starts");
    applyStimulus(0, 16'hFFFE, 1'b1, 0, 1'b1);
    for (int k = 0; k < 4; k++)
      applyStimulus(k % 3, 16'($urandom), 1'b1, k % 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
